vector_alu_seq: RTL and testbench
=================================

Name: vector_alu_seq

Overview:
- Vector execute-stage ALU directly downstream of the ALU decoder.
- Consumes the 3-bit ALU control code and the SrcA select, and operates on LANES independent unsigned lanes.
- Single-cycle ops finish in one cycle, MUL in two; DIV is an iterative restoring divider (all lanes in parallel, one quotient bit per cycle).
- Presents a registered result with a start/busy/done handshake to the writeback stage.

Parameters:
- LANES, 4, number of vector lanes.
- LW, 16, lane width in bits.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- start  in  1  launch op; sampled only in IDLE.
- alu_control  in  3  op code: 000 ADD, 001 SUB, 010 MOV, 011 MUL, 100 DIV, 101 CMP, 110 NOP, 111 DUP.
- src_a  in  1  1 = operand A forced to zero; 0 = vec_a.
- vec_a  in  LANES*LW  operand A; lane i = bits [i*LW +: LW].
- vec_b  in  LANES*LW  operand B.
- result  out  LANES*LW  registered result vector.
- cmp_eq  out  LANES  per-lane A==B, from CMP.
- cmp_lt  out  LANES  per-lane A<B (unsigned), from CMP.
- div_by_zero  out  LANES  per-lane B==0 flag, from DIV.
- wr_en  out  1  result valid for register write; asserted with done.
- busy  out  1  op in flight.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (reset==0 at an edge): state→IDLE. result, cmp_eq, cmp_lt, div_by_zero, wr_en, busy and done all → 0. Takes priority over everything, including mid-DIV; partial quotients are discarded.
- Operand capture: vec_a (after the src_a mux), vec_b and alu_control are latched on the accepting edge. Later input changes have no effect until the next accept.
- FSM states:
  - IDLE: start=1 → accept. MUL → MUL2, DIV → DIV_ITER, all other ops → FIN.
  - MUL2: 1 cycle, registers the low LW bits of the per-lane product → FIN.
  - DIV_ITER: LW cycles, one restoring step per cycle, step counter 0..LW-1. Counter == LW-1 → FIN.
  - FIN: drive result/flags, pulse done for 1 cycle → IDLE.
- busy is 1 in MUL2, DIV_ITER and FIN; 0 in IDLE.
- Latency, accept edge to done high:
  - ADD/SUB/MOV/CMP/NOP/DUP: 1 cycle.
  - MUL: 2 cycles.
  - DIV: LW+1 cycles.
- Back-to-back ops: start with busy=1 is ignored, not queued. start in the cycle done is high is also ignored. The earliest next accept is the cycle after done.
- Per-lane arithmetic, all unsigned and modulo 2^LW:
  - ADD: A+B.
  - SUB: A-B.
  - MOV: B (A ignored).
  - MUL: low LW bits of A*B.
  - DIV: A/B quotient; remainder discarded.
  - DUP: lane 0 of B broadcast to every lane.
- wr_en: equals done for ADD/SUB/MOV/MUL/DIV/DUP; 0 for CMP and NOP.
- On CMP and NOP, result holds its previous value.
- CMP: updates cmp_eq and cmp_lt in FIN; result unchanged.
- Other ops: cmp_* and div_by_zero hold their previous values, except DIV, which rewrites div_by_zero.
- DIV with B lane == 0: quotient lane = all ones, div_by_zero[i]=1. Other lanes are unaffected.
- start and reset in the same cycle: reset wins; no op is accepted.

Optional Feature:
- Macro: VALU_SAT_EN.
- Defined: ADD saturates to 2^LW-1 on carry-out; SUB clamps to 0 on borrow. MUL also saturates to 2^LW-1 when the high product bits are nonzero.
- Undefined: all ops wrap modulo 2^LW as above.
- Either way, latency and handshake are unchanged.

Decomposition:
- Package valu_pkg holds:
  - typedef enum logic [2:0] alu_op_t, with the codes listed under Ports.
  - typedef enum fsm state_t {IDLE, MUL2, DIV_ITER, FIN}.
  - Default LANES/LW localparams and the lane-slice helper function.
- Sub-module valu_lane_div: one lane's restoring divider. Holds the remainder/quotient registers and the single-step subtract/shift, with a load strobe and a step enable. Instantiated LANES times via generate.
- The FSM, step counter and single-cycle ops live in the top module.

Test Plan:
- ADD, lanes A={1,2,3,0xFFFF}, B={1,1,1,1}, src_a=0 → done 1 cycle after accept. result={2,3,4,0x0000}, wr_en=1; with VALU_SAT_EN, lane3=0xFFFF.
- MOV, src_a=1, B={5,6,7,8}, A=garbage → result={5,6,7,8}. DUP with B lane0=0x1234 → all lanes 0x1234.
- MUL, A={300,2,0,0x100}, B={300,3,9,0x100} → done exactly 2 cycles after accept. result={0x5F90,6,0,0x0000}; with VALU_SAT_EN, lanes 0 and 3 = 0xFFFF.
- DIV, A={100,7,0xFFFF,9}, B={7,7,1,0} → busy for 17 cycles, done at cycle 17. result={14,1,0xFFFF,0xFFFF}, div_by_zero=4'b1000. A second start raised mid-DIV is ignored.
- CMP, A={3,5,5,0}, B={5,5,3,0} → cmp_eq=4'b1010, cmp_lt=4'b0001, wr_en=0, result unchanged. NOP → done=1, wr_en=0.
- Reset pulled low at DIV step 8 → next edge: state IDLE, all outputs 0. A fresh ADD accepted the cycle after reset releases completes normally.

Source files
------------

// File: rtl/valu_pkg.sv
// valu_pkg: op/state encodings, default vector sizes and lane-slice helper for vector_alu_seq
package valu_pkg;
   localparam int VALU_LANES = 4;
   localparam int VALU_LW = 16;
   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_MOV = 3'b010,
      OP_MUL = 3'b011,
      OP_DIV = 3'b100,
      OP_CMP = 3'b101,
      OP_NOP = 3'b110,
      OP_DUP = 3'b111
   } alu_op_t;
   typedef enum logic [1:0] {IDLE, MUL2, DIV_ITER, FIN} state_t;
   function automatic int lane_lo(input int lane, input int lw);
      return lane * lw;
   endfunction
endpackage

// File: rtl/valu_lane_div.sv
// valu_lane_div: one lane of the restoring divider, one quotient bit per step
module valu_lane_div #(
   parameter int LW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic          step,
   input  logic [LW-1:0] dividend,
   input  logic [LW-1:0] divisor,
   output logic [LW-1:0] quotient
);
   logic [LW-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [LW:0] shl, dif;
   // shift next dividend bit into the remainder and keep the difference only if it did not borrow;
   // a zero divisor never borrows, so its quotient naturally fills with ones
   always_comb begin
      shl = {rem_q, quo_q[LW-1]};
      dif = shl - {1'b0, dvs_q};
      rem_d = load ? '0 : step ? (dif[LW] ? shl[LW-1:0] : dif[LW-1:0]) : rem_q;
      quo_d = load ? dividend : step ? {quo_q[LW-2:0], ~dif[LW]} : quo_q;
      dvs_d = load ? divisor : dvs_q;
   end
   // divider registers, cleared by the active-low synchronous reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         dvs_q <= dvs_d;
      end
   end
   assign quotient = quo_q;
endmodule

// File: rtl/vector_alu_seq.sv
// vector_alu_seq: multi-cycle vector ALU with start/busy/done handshake; VALU_SAT_EN selects saturating ADD/SUB/MUL
module vector_alu_seq
   import valu_pkg::*;
#(
   parameter int LANES = VALU_LANES,
   parameter int LW = VALU_LW
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [2:0]          alu_control,
   input  logic                src_a,
   input  logic [LANES*LW-1:0] vec_a,
   input  logic [LANES*LW-1:0] vec_b,
   output logic [LANES*LW-1:0] result,
   output logic [LANES-1:0]    cmp_eq,
   output logic [LANES-1:0]    cmp_lt,
   output logic [LANES-1:0]    div_by_zero,
   output logic                wr_en,
   output logic                busy,
   output logic                done
);
   localparam int CW = $clog2(LW);
   state_t state_q, state_d;
   alu_op_t op_q, op_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [LANES*LW-1:0] a_q, a_d, b_q, b_d, prod_q, prod_d, res_q, res_d, a_in;
   logic [LANES-1:0] eq_q, eq_d, lt_q, lt_d, dz_q, dz_d, eq_l, lt_l, dz_l;
   logic wr_q, wr_d, done_q, done_d, accept;
   logic [LANES-1:0][LW-1:0] add_l, sub_l, mul_l, quo_l;

   assign a_in = src_a ? '0 : vec_a;
   assign accept = start && state_q == IDLE && !done_q;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [LW-1:0] a, b;
      assign a = a_q[lane_lo(i, LW) +: LW];
      assign b = b_q[lane_lo(i, LW) +: LW];
`ifdef VALU_SAT_EN
      logic [LW:0] sum, dif;
      logic [2*LW-1:0] prod;
      assign sum = {1'b0, a} + {1'b0, b};
      assign dif = {1'b0, a} - {1'b0, b};
      assign prod = {{LW{1'b0}}, a} * {{LW{1'b0}}, b};
      assign add_l[i] = sum[LW] ? '1 : sum[LW-1:0];
      assign sub_l[i] = dif[LW] ? '0 : dif[LW-1:0];
      assign mul_l[i] = |prod[2*LW-1:LW] ? '1 : prod[LW-1:0];
`else
      assign add_l[i] = a + b;
      assign sub_l[i] = a - b;
      assign mul_l[i] = a * b;
`endif
      assign eq_l[i] = a == b;
      assign lt_l[i] = a < b;
      assign dz_l[i] = b == '0;
      valu_lane_div #(.LW(LW)) u_div (
         .clk     (clk),
         .reset   (reset),
         .load    (accept),
         .step    (state_q == DIV_ITER),
         .dividend(a_in[lane_lo(i, LW) +: LW]),
         .divisor (vec_b[lane_lo(i, LW) +: LW]),
         .quotient(quo_l[i])
      );
   end

   // sequencing: capture operands on accept, register the product in MUL2, count divide steps,
   // and in FIN commit result/flags for the latched op and raise the done pulse
   always_comb begin
      state_d = state_q;
      op_d = op_q;
      cnt_d = cnt_q;
      a_d = a_q;
      b_d = b_q;
      prod_d = prod_q;
      res_d = res_q;
      eq_d = eq_q;
      lt_d = lt_q;
      dz_d = dz_q;
      wr_d = 1'b0;
      done_d = 1'b0;
      case (state_q)
         IDLE: if (accept) begin
            op_d = alu_op_t'(alu_control);
            a_d = a_in;
            b_d = vec_b;
            cnt_d = '0;
            if (alu_control == OP_MUL) state_d = MUL2;
            else if (alu_control == OP_DIV) state_d = DIV_ITER;
            else state_d = FIN;
         end
         MUL2: begin
            prod_d = mul_l;
            state_d = FIN;
         end
         DIV_ITER: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(LW - 1)) state_d = FIN;
         end
         default: begin
            state_d = IDLE;
            done_d = 1'b1;
            wr_d = op_q != OP_CMP && op_q != OP_NOP;
            res_d = op_q == OP_ADD ? add_l :
                    op_q == OP_SUB ? sub_l :
                    op_q == OP_MOV ? b_q :
                    op_q == OP_MUL ? prod_q :
                    op_q == OP_DIV ? quo_l :
                    op_q == OP_DUP ? {LANES{b_q[LW-1:0]}} : res_q;
            eq_d = op_q == OP_CMP ? eq_l : eq_q;
            lt_d = op_q == OP_CMP ? lt_l : lt_q;
            dz_d = op_q == OP_DIV ? dz_l : dz_q;
         end
      endcase
   end

   // state and output registers; reset aborts any op in flight
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         op_q <= OP_NOP;
         cnt_q <= '0;
         a_q <= '0;
         b_q <= '0;
         prod_q <= '0;
         res_q <= '0;
         eq_q <= '0;
         lt_q <= '0;
         dz_q <= '0;
         wr_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q <= op_d;
         cnt_q <= cnt_d;
         a_q <= a_d;
         b_q <= b_d;
         prod_q <= prod_d;
         res_q <= res_d;
         eq_q <= eq_d;
         lt_q <= lt_d;
         dz_q <= dz_d;
         wr_q <= wr_d;
         done_q <= done_d;
      end
   end

   assign result = res_q;
   assign cmp_eq = eq_q;
   assign cmp_lt = lt_q;
   assign div_by_zero = dz_q;
   assign wr_en = wr_q;
   assign done = done_q;
   assign busy = state_q != IDLE;
endmodule

// File: tb/tb_vector_alu_seq.sv
// tb_vector_alu_seq: table-driven directed checks plus mid-divide start and reset sequences
module tb_vector_alu_seq;
   logic clk = 1'b0, reset = 1'b0, start = 1'b0, src_a = 1'b0;
   logic [2:0] alu_control = 3'b000;
   logic [63:0] vec_a = '0, vec_b = '0, result;
   logic [3:0] cmp_eq, cmp_lt, div_by_zero;
   logic wr_en, busy, done;
   int n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   vector_alu_seq dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .alu_control(alu_control),
      .src_a      (src_a),
      .vec_a      (vec_a),
      .vec_b      (vec_b),
      .result     (result),
      .cmp_eq     (cmp_eq),
      .cmp_lt     (cmp_lt),
      .div_by_zero(div_by_zero),
      .wr_en      (wr_en),
      .busy       (busy),
      .done       (done)
   );

`ifdef VALU_SAT_EN
   localparam logic [63:0] ADD_R = 64'hFFFF_0004_0003_0002;
   localparam logic [63:0] SUB_R = 64'h7FFF_0000_0000_0007;
   localparam logic [63:0] MUL_R = 64'hFFFF_0000_0006_FFFF;
   localparam logic [63:0] SUB2_R = 64'h0000_0000_0000_0000;
`else
   localparam logic [63:0] ADD_R = 64'h0000_0004_0003_0002;
   localparam logic [63:0] SUB_R = 64'h7FFF_FFFF_0000_0007;
   localparam logic [63:0] MUL_R = 64'h0000_0000_0006_5F90;
   localparam logic [63:0] SUB2_R = 64'h0000_0000_FFFF_0000;
`endif
   localparam logic [63:0] DIV_R = 64'hFFFF_FFFF_0001_000E;

   typedef struct {
      logic [2:0]  op;
      logic        sa;
      logic [63:0] a, b, res;
      logic [3:0]  eq, lt, dz;
      logic        wr;
      int          lat;
   } vec_t;
   vec_t tv [10];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic run_op(input logic [2:0] op, input logic sa, input logic [63:0] a, input logic [63:0] b,
                         output int lat);
      @(negedge clk);
      start = 1'b1;
      alu_control = op;
      src_a = sa;
      vec_a = a;
      vec_b = b;
      @(negedge clk);
      start = 1'b0;
      alu_control = 3'b110;
      src_a = 1'b0;
      vec_a = ~a;
      vec_b = ~b;
      lat = 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int lat, nb;
      tv[0] = '{3'b000, 1'b0, 64'hFFFF_0003_0002_0001, 64'h0001_0001_0001_0001, ADD_R, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1};
      tv[1] = '{3'b001, 1'b0, 64'h8000_0000_0005_000A, 64'h0001_0001_0005_0003, SUB_R, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1};
      tv[2] = '{3'b010, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 64'h0008_0007_0006_0005, 64'h0008_0007_0006_0005, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1};
      tv[3] = '{3'b111, 1'b0, 64'h5555_6666_7777_8888, 64'h0009_0008_0007_1234, 64'h1234_1234_1234_1234, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1};
      tv[4] = '{3'b011, 1'b0, 64'h0100_0000_0002_012C, 64'h0100_0009_0003_012C, MUL_R, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2};
      tv[5] = '{3'b101, 1'b0, 64'h0000_0005_0005_0003, 64'h0000_0003_0005_0005, MUL_R, 4'b1010, 4'b0001, 4'b0000, 1'b0, 1};
      tv[6] = '{3'b110, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, MUL_R, 4'b1010, 4'b0001, 4'b0000, 1'b0, 1};
      tv[7] = '{3'b100, 1'b0, 64'h0009_FFFF_0007_0064, 64'h0000_0001_0007_0007, DIV_R, 4'b1010, 4'b0001, 4'b1000, 1'b1, 17};
      tv[8] = '{3'b000, 1'b1, 64'h1111_2222_3333_4444, 64'h0004_0003_0002_0001, 64'h0004_0003_0002_0001, 4'b1010, 4'b0001, 4'b1000, 1'b1, 1};
      tv[9] = '{3'b001, 1'b1, 64'h9999_8888_7777_6666, 64'h0000_0000_0001_0000, SUB2_R, 4'b1010, 4'b0001, 4'b1000, 1'b1, 1};

      repeat (2) @(negedge clk);
      chk("rst result", result, 64'h0);
      chk("rst flags", {52'h0, cmp_eq, cmp_lt, div_by_zero}, 64'h0);
      chk("rst ctl", {61'h0, wr_en, busy, done}, 64'h0);
      reset = 1'b1;

      for (int k = 0; k < 10; k++) begin
         run_op(tv[k].op, tv[k].sa, tv[k].a, tv[k].b, lat);
         chk($sformatf("v%0d latency", k), 64'(lat), 64'(tv[k].lat));
         chk($sformatf("v%0d result", k), result, tv[k].res);
         chk($sformatf("v%0d cmp_eq", k), 64'(cmp_eq), 64'(tv[k].eq));
         chk($sformatf("v%0d cmp_lt", k), 64'(cmp_lt), 64'(tv[k].lt));
         chk($sformatf("v%0d div_by_zero", k), 64'(div_by_zero), 64'(tv[k].dz));
         chk($sformatf("v%0d wr_en", k), 64'(wr_en), 64'(tv[k].wr));
      end

      // divide with a stray start mid-flight and another start during the done cycle
      @(negedge clk);
      start = 1'b1;
      alu_control = 3'b100;
      vec_a = 64'h0030_0020_0010_0064;
      vec_b = 64'h0003_0000_0001_000A;
      @(negedge clk);
      alu_control = 3'b000;
      vec_a = 64'h0001_0001_0001_0001;
      vec_b = 64'h0001_0001_0001_0001;
      lat = 0;
      nb = 0;
      start = 1'b0;
      while (!done && lat < 40) begin
         if (busy) nb++;
         start = (lat == 5);
         @(negedge clk);
         lat++;
      end
      chk("div2 latency", 64'(lat), 64'd17);
      chk("div2 busy cycles", 64'(nb), 64'd17);
      chk("div2 result", result, 64'h0010_FFFF_0010_000A);
      chk("div2 div_by_zero", 64'(div_by_zero), 64'h4);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start in done cycle busy", 64'(busy), 64'h0);
      chk("start in done cycle done", 64'(done), 64'h0);

      // reset during divide step 8, with start asserted alongside
      @(negedge clk);
      start = 1'b1;
      alu_control = 3'b100;
      vec_a = 64'h0009_FFFF_0007_0064;
      vec_b = 64'h0000_0001_0007_0007;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      chk("pre-reset busy", 64'(busy), 64'h1);
      reset = 1'b0;
      start = 1'b1;
      alu_control = 3'b000;
      @(negedge clk);
      chk("mid-div reset result", result, 64'h0);
      chk("mid-div reset flags", {52'h0, cmp_eq, cmp_lt, div_by_zero}, 64'h0);
      chk("mid-div reset ctl", {61'h0, wr_en, busy, done}, 64'h0);
      reset = 1'b1;
      start = 1'b0;
      @(negedge clk);
      chk("post-reset idle", {62'h0, busy, done}, 64'h0);
      run_op(3'b000, 1'b0, 64'h0001_0001_0001_0001, 64'h0002_0002_0002_0002, lat);
      chk("post-reset add latency", 64'(lat), 64'd1);
      chk("post-reset add result", result, 64'h0003_0003_0003_0003);
      chk("post-reset add wr_en", 64'(wr_en), 64'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
